// File: rtl/spi_frame_counter.sv
// Synchronous SPI frame counter with start/busy/done handshake and abort.
// Define SPI_FRAME_COUNTER_DIR_EN to add the dir port for down-counting frames.
module spi_frame_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] limit,
`ifdef SPI_FRAME_COUNTER_DIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             last,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] lim_n;
  logic             dir_q;
  logic             dir_n;
  logic             dir_in;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] end_val;
  logic             at_end;

`ifdef SPI_FRAME_COUNTER_DIR_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  assign end_val = dir_q ? '0 : lim_q;
  assign at_end  = (cnt_q == end_val);

  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    lim_n   = lim_q;
    dir_n   = dir_q;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          lim_n   = limit;
          dir_n   = dir_in;
          cnt_n   = dir_in ? limit : '0;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        // abort wins over a coincident tick
        if (abort) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (enable && at_end) begin
          state_n = DONE;
        end else if (enable) begin
          cnt_n = dir_q ? cnt_q - WIDTH'(1)
                        : cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt_q  <= '0;
      lim_q  <= '0;
      dir_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt_q  <= cnt_n;
      lim_q  <= lim_n;
      dir_q  <= dir_n;
      busy_q <= (state_n == RUN);
      done_q <= (state_n == DONE);
    end
  end

  assign count = cnt_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign last  = busy_q && at_end;

endmodule

// File: tb/tb_spi_frame_counter.sv
// Self-checking bench for spi_frame_counter: directed scenarios plus
// randomized traffic against a tick-counting reference model.
module tb_spi_frame_counter;

  localparam int W = 3;
`ifdef SPI_FRAME_COUNTER_DIR_EN
  localparam bit DIRON = 1'b1;
`else
  localparam bit DIRON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] limit = '0;
  logic         dir = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         last;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  // model: frame described by latched length and ticks taken so far
  bit m_busy;
  bit m_done;
  bit m_dir;
  int m_lim;
  int m_ticks;
  int m_count;

  always #5 clk = ~clk;

  spi_frame_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .start  (start),
    .abort  (abort),
    .limit  (limit),
`ifdef SPI_FRAME_COUNTER_DIR_EN
    .dir    (dir),
`endif
    .count  (count),
    .busy   (busy),
    .last   (last),
    .done   (done)
  );

  task automatic model_reset();
    m_busy  = 0;
    m_done  = 0;
    m_dir   = 0;
    m_lim   = 0;
    m_ticks = 0;
    m_count = 0;
  endtask

  // advance one clock edge and the model with it
  task automatic tick();
    @(posedge clk);
    if (m_busy) begin
      m_done = 0;
      if (abort) begin
        m_busy  = 0;
        m_count = 0;
      end else if (enable) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == m_lim + 1) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_count = m_dir ? m_lim - m_ticks : m_ticks;
        end
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_lim   = int'(limit);
        m_dir   = DIRON ? dir : 1'b0;
        m_ticks = 0;
        m_busy  = 1;
        m_count = m_dir ? m_lim : 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #12;
    n_cmp++;
    if ({count, busy, done, last} !== {3'd0, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got c=%0d b=%0b d=%0b l=%0b want 0 0 0 0",
               count, busy, done, last);
    end
    @(negedge clk);
    rst = 1'b0;
    limit = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (count !== 3'd5) begin
      n_err++;
      $display("FAIL pre_reset_count: got %0d want 5", count);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({count, busy, done, last} !== {3'd0, 3'b000}) begin
      n_err++;
      $display("FAIL async_reset: got c=%0d b=%0b d=%0b l=%0b want 0 0 0 0",
               count, busy, done, last);
    end
    model_reset();
    enable = 1'b0;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    logic [W+2:0] exp;
    limit = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    n_cmp++;
    if ({count, busy, last, done} !== {3'd0, 3'b100}) begin
      n_err++;
      $display("FAIL full_load: got c=%0d b=%0b l=%0b d=%0b want 0 1 0 0",
               count, busy, last, done);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp = {W'(i), 1'b1, (i == 7), 1'b0};
      n_cmp++;
      if ({count, busy, last, done} !== exp) begin
        n_err++;
        $display("FAIL full_tick%0d: got c=%0d b=%0b l=%0b d=%0b want %0d 1 %0b 0",
                 i, count, busy, last, done, i, (i == 7));
      end
    end
    tick();
    n_cmp++;
    if ({count, busy, last, done} !== {3'd7, 3'b001}) begin
      n_err++;
      $display("FAIL full_done: got c=%0d b=%0b l=%0b d=%0b want 7 0 0 1",
               count, busy, last, done);
    end
    enable = 1'b0;
    tick();
    n_cmp++;
    if ({count, busy, last, done} !== {3'd7, 3'b000}) begin
      n_err++;
      $display("FAIL full_idle: got c=%0d b=%0b l=%0b d=%0b want 7 0 0 0",
               count, busy, last, done);
    end
  endtask

  task automatic test_limit_change();
    int en_cnt = 0;
    int ndone = 0;
    int at_done = -1;
    int c_done = -1;
    limit = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      enable = (cyc % 3 == 2);
      if (en_cnt == 2) limit = 3'd6;
      tick();
      if (enable) en_cnt++;
      if (done) begin
        ndone++;
        at_done = en_cnt;
        c_done = int'(count);
      end
    end
    enable = 1'b0;
    n_cmp++;
    if (ndone != 1 || at_done != 4 || c_done != 3) begin
      n_err++;
      $display("FAIL limit_change: got pulses=%0d ticks=%0d cnt=%0d want 1 4 3",
               ndone, at_done, c_done);
    end
  endtask

  task automatic test_abort();
    int saw_done = 0;
    limit = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if ({count, busy, done} !== {3'd0, 2'b00}) begin
      n_err++;
      $display("FAIL abort: got c=%0d b=%0b d=%0b want 0 0 0",
               count, busy, done);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) saw_done++;
    end
    enable = 1'b0;
    n_cmp++;
    if (saw_done != 0) begin
      n_err++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", saw_done);
    end
  endtask

  task automatic test_back_to_back();
    limit = 3'd0;
    start = 1'b1;
    tick();
    n_cmp++;
    if ({count, busy, last, done} !== {3'd0, 3'b110}) begin
      n_err++;
      $display("FAIL b2b_load0: got c=%0d b=%0b l=%0b d=%0b want 0 1 1 0",
               count, busy, last, done);
    end
    enable = 1'b1;
    limit = 3'd2;
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_done1: got b=%0b d=%0b want 0 1", busy, done);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if ({count, busy, done} !== {3'd0, 2'b10}) begin
      n_err++;
      $display("FAIL b2b_restart: got c=%0d b=%0b d=%0b want 0 1 0",
               count, busy, done);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_cmp++;
      if ({count, busy, last} !== {W'(i), 1'b1, (i == 2)}) begin
        n_err++;
        $display("FAIL b2b_cnt%0d: got c=%0d b=%0b l=%0b want %0d 1 %0b",
                 i, count, busy, last, i, (i == 2));
      end
    end
    tick();
    enable = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_done2: got b=%0b d=%0b want 0 1", busy, done);
    end
    tick();
  endtask

  task automatic test_dir();
    int e;
    dir = 1'b1;
    limit = 3'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    dir = 1'b0;
    enable = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) tick();
      e = DIRON ? 5 - i : i;
      n_cmp++;
      if ({count, busy, last} !== {W'(e), 1'b1, (i == 5)}) begin
        n_err++;
        $display("FAIL dir_step%0d: got c=%0d b=%0b l=%0b want %0d 1 %0b",
                 i, count, busy, last, e, (i == 5));
      end
    end
    tick();
    enable = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_err++;
      $display("FAIL dir_done: got b=%0b d=%0b want 0 1", busy, done);
    end
    tick();
  endtask

  task automatic test_random();
    bit e_last;
    for (int i = 0; i < 600; i++) begin
      limit  = W'($urandom);
      dir    = 1'($urandom);
      start  = ($urandom_range(0, 3) == 0);
      enable = 1'($urandom_range(0, 1));
      abort  = ($urandom_range(0, 24) == 0);
      tick();
      e_last = m_busy && (m_ticks == m_lim);
      n_cmp++;
      if ({count, busy, done, last} !== {W'(m_count), m_busy, m_done, e_last}) begin
        n_err++;
        $display("FAIL random%0d: got c=%0d b=%0b d=%0b l=%0b want %0d %0b %0b %0b",
                 i, count, busy, done, last, m_count, m_busy, m_done, e_last);
      end
    end
    start = 1'b0;
    enable = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_limit_change();
    test_abort();
    test_back_to_back();
    test_dir();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_frame_counter.md
# spi_frame_counter

Parametrised synchronous frame counter for the SPI datapath. It counts qualified bit ticks from a programmable start value to a latched terminal value. It runs a start/busy/done handshake so the shift logic knows when a frame of `limit+1` bits has completed. It is the successor to the ripple counter: fully synchronous, width-generic, abortable, optionally bidirectional.

## Interface
- `WIDTH`, default 3: counter width; frames of 1 to 2^WIDTH ticks.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  tick qualifier (one-cycle strobe per SPI bit); counts only in RUN.
- `start`  in  1  request a new frame; sampled in IDLE and DONE.
- `abort`  in  1  cancel the frame in progress; no `done` is produced.
- `limit`  in  WIDTH  terminal value; latched on an accepted `start`.
- `dir`  in  1  0 = up, 1 = down; latched on an accepted `start`. Present only with `SPI_FRAME_COUNTER_DIR_EN`.
- `count`  out  WIDTH  current count, registered.
- `busy`  out  1  high while in RUN, registered.
- `last`  out  1  combinational: busy && count == end value. Marks the final bit of the frame.
- `done`  out  1  one-cycle pulse after the final tick, registered.

## Operation
- Latched registers:
  - `lim_q`: latched `limit`.
  - `dir_q`: latched `dir`; tied 0 without the macro.
- Start and end values:
  - Up counting: start value = 0, end value = `lim_q`.
  - Down counting: start value = `lim_q`, end value = 0.
- State machine, states IDLE, RUN, DONE:
  - IDLE:
    - `start`=1 → RUN. Latch `limit`/`dir`, load `count` with the start value.
    - Otherwise hold; `count` keeps its previous value.
    - `enable` and `abort` are ignored.
  - RUN:
    - `abort`=1 → IDLE with `count`=0. Abort has priority over `enable`.
    - Else if `enable`=1 and `count`==end value → DONE; `count` holds.
    - Else if `enable`=1 → `count` ± 1 (modulo 2^WIDTH; the end value is reached before any wrap).
    - `start` is ignored.
  - DONE:
    - `done`=1 for exactly this cycle.
    - `start`=1 → RUN with a fresh latch and load (back-to-back frames, no IDLE cycle).
    - Otherwise → IDLE.
- Frame length is `limit`+1 `enable` ticks; `limit`=0 gives one tick.
- Changes on `limit`/`dir` during RUN have no effect until the next accepted `start`.

## Timing
- Reset (asynchronous, immediate): state IDLE, `count`=0, `busy`=0, `done`=0, `lim_q`=0, `dir_q`=0; `last`=0 follows.
- Counting:
  - `start` sampled at edge k → `busy`=1 and `count`=start value after edge k.
  - The n-th `enable` in RUN updates `count` at that edge.
  - The (`limit`+1)-th `enable`, at edge m → `busy`=0 and `done`=1 after edge m; `done`=0 after edge m+1.
- Minimum frame: start-to-done latency is 2 cycles with `enable` held high and `limit`=0.
- Back-to-back: with `start`=1 in DONE, `busy` is low for exactly one cycle between frames.
- Abort: `abort` at edge a → `busy`=0, `count`=0 after edge a; `done` never asserts for that frame.
- Reset mid-frame returns to IDLE immediately without `done`.
- `last` follows registered state combinationally; no added latency.

## Configuration
- `SPI_FRAME_COUNTER_DIR_EN` defined:
  - The `dir` port exists and is latched on start.
  - Down frames load `limit` and end at 0.
- Not defined:
  - No `dir` port; `dir_q` is constant 0.
  - Up counting only; all other behaviour is identical.

## Test plan
- Reset with `count` mid-frame (`count`=5, `WIDTH`=3) → `count`=0, `busy`=0, `done`=0 asynchronously, before the next clock edge.
- `limit`=7, `start` pulse, `enable` held high → `count` 0..7 on successive edges. `last`=1 while `count`=7. `done`=1 one cycle after the 8th tick, then IDLE.
- `limit`=3, `enable` every 3rd cycle, `limit` changed to 6 mid-frame → frame still ends after 4 ticks; `done` pulses once.
- `limit`=7, `abort` asserted together with the 4th `enable` → `count`=0, `busy`=0 next cycle, `done` never asserts.
- `limit`=0 frame followed by `start`=1 during DONE with `limit`=2 → first `done` after 1 tick. `busy` is low for exactly one cycle, then the second frame counts 0,1,2.
- With `SPI_FRAME_COUNTER_DIR_EN`, `dir`=1, `limit`=5 → `count` runs 5,4,3,2,1,0 with `last` at 0, and `done` follows 6 ticks. Without the macro, the same stimulus counts up 0..5.
